midi_tx_arbiter: RTL and testbench
==================================

MIDI_TX_ARBITER -- requirements
Module: midi_tx_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_TICKS, default 255, meaning the number of clk_en ticks a granted requester may idle mid-message before its grant is revoked (legal 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port clk_en, input, 1 bit: timebase tick from the clock-enable generator, one clk wide.
REQ-005 The block SHALL have port req, input, 4 bits: per-requester byte-available flag.
REQ-006 The block SHALL have port data, input, 32 bits: four packed bytes; requester i drives bits [8i+7:8i].
REQ-007 The block SHALL have port last, input, 4 bits: marks the current byte of requester i as the final byte of its MIDI message.
REQ-008 The block SHALL have port ack, output, 4 bits: one-clk pulse when requester i's byte is accepted.
REQ-009 The block SHALL have port grant, output, 4 bits: one-hot current owner, or all zero.
REQ-010 The block SHALL have port tx_valid, output, 1 bit: byte presented to the shared UART transmitter.
REQ-011 The block SHALL have port tx_data, output, 8 bits: byte for the transmitter.
REQ-012 The block SHALL have port tx_ready, input, 1 bit: transmitter can accept a byte this cycle.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: one-clk pulse when a grant is revoked by timeout.

Function
REQ-014 The FSM SHALL have states IDLE, ARB and XFER.
REQ-015 In IDLE, when any req bit is 1, the FSM SHALL move to ARB; otherwise it SHALL stay in IDLE with grant = 0.
REQ-016 In ARB, the block SHALL register the winner: the first requester with req = 1, searching upward from the rotation pointer and wrapping 3 to 0; grant SHALL assert on the next cycle, in XFER.
REQ-017 If req is all zero in ARB, the FSM SHALL return to IDLE with no grant.
REQ-018 In XFER, tx_valid SHALL equal req[owner] and tx_data SHALL equal the owner's data byte, both combinational.
REQ-019 A transfer SHALL occur in a cycle with tx_valid = 1 and tx_ready = 1; in that cycle ack[owner] SHALL be 1 and all other ack bits SHALL be 0.
REQ-020 On a transfer with last[owner] = 1, the FSM SHALL go to IDLE, clear grant, and set the rotation pointer to owner+1 mod 4.
REQ-021 Grant SHALL hold across all bytes of a message; no other requester's byte SHALL reach tx_data until the owner's last byte transfers or the grant times out.
REQ-022 The idle counter (8 bits) SHALL increment on each clk_en while in XFER with req[owner] = 0.
REQ-023 The idle counter SHALL clear on entry to XFER, on any transfer, and on any cycle with req[owner] = 1.
REQ-024 When the idle counter reaches TIMEOUT_TICKS, the block SHALL pulse timeout_err, go to IDLE, clear grant, and advance the pointer to owner+1.
REQ-025 If req[owner] rises in the same cycle the counter would reach TIMEOUT_TICKS, the counter clear SHALL win and no timeout SHALL occur.
REQ-026 Outside XFER, tx_valid and ack SHALL be 0.
REQ-027 tx_ready SHALL be ignored outside XFER.

Reset
REQ-028 When rst = 1 at a clk edge, the block SHALL set state = IDLE, pointer = 0, grant = 0, idle counter = 0 and timeout_err = 0; tx_valid and ack SHALL be 0 in the following cycle.
REQ-029 A reset mid-message SHALL abandon the message with no ack and no timeout_err.
REQ-030 The arbiter SHALL resume normally from the first clk edge with rst = 0.

Structure
REQ-031 The shared package SHALL hold the FSM state encodings, NUM_REQ = 4 and the MIDI byte width of 8.
REQ-032 The block SHALL contain one sub-module, rr_pick4: combinational round-robin winner selection from req and pointer.

Verification
REQ-033 Single message: rst, then req[2]=1 with bytes 0x90, 0x3C, 0x7F and last on 0x7F, tx_ready=1 -> grant=0100 two clks after req, three ack[2] pulses, tx_data sequence 90,3C,7F, then IDLE.
REQ-034 Contention: req=1111 from the pointer=0 state -> messages are served in order 0,1,2,3 and grant never changes mid-message.
REQ-035 Backpressure: tx_ready=0 for 5 clks mid-message -> tx_valid held high, tx_data stable, no ack until tx_ready=1.
REQ-036 Timeout: TIMEOUT_TICKS=3, owner drops req after its first byte, clk_en every 4 clks -> timeout_err pulses on the 3rd clk_en, grant clears, and a waiting req[3] is granted next.
REQ-037 Race: req[owner] reasserts in the same cycle as the 3rd clk_en -> no timeout_err and the message continues.
REQ-038 Reset mid-message: rst asserted after byte 1 of 3 -> grant=0 and tx_valid=0 the next clk, and the pointer is 0.

Source files
------------

// File: rtl/midi_tx_arbiter_pkg.sv
// Shared types and constants for the MIDI transmit arbiter.
package midi_tx_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArb  = 2'd1,
        StXfer = 2'd2
    } state_e;

    // Requester index to one-hot grant/ack vector.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/midi_tx_arbiter_rr_pick4.sv
// Combinational round-robin winner selection over four requesters.
module rr_pick4
    import midi_tx_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic [IDX_W-1:0] cand;

    // First requesting index at or above the pointer, wrapping 3 -> 0.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = ptr_i;
        cand    = ptr_i;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ptr_i + IDX_W'(k);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/midi_tx_arbiter.sv
// Four-way message-granular arbiter feeding one shared MIDI UART transmitter.
// A granted requester keeps the transmitter until its last byte goes out or it
// idles for TIMEOUT_TICKS timebase ticks mid-message.
module midi_tx_arbiter
    import midi_tx_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*BYTE_W-1:0] data,
    input  logic [NUM_REQ-1:0]        last,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      tx_valid,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_ready,
    output logic                      timeout_err
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT_TICKS);

    state_e             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [CNT_W-1:0]   idle_cnt_q;
    logic               timeout_err_q;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [BYTE_W-1:0]  byte_arr [NUM_REQ];

    logic               in_xfer;
    logic               owner_req;
    logic               owner_last;
    logic               xfer_fire;
    logic [CNT_W-1:0]   idle_cnt_d;
    logic               timeout_hit;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign byte_arr[g] = data[g*BYTE_W +: BYTE_W];
    end

    rr_pick4 u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Datapath to the transmitter and the transfer/idle-tick decode.
    always_comb begin
        in_xfer     = (state_q == StXfer);
        owner_req   = req[owner_q];
        owner_last  = last[owner_q];
        tx_valid    = in_xfer & owner_req;
        tx_data     = in_xfer ? byte_arr[owner_q] : '0;
        xfer_fire   = tx_valid & tx_ready;
        ack         = xfer_fire ? idx_to_onehot(owner_q) : '0;
        idle_cnt_d  = idle_cnt_q + CNT_W'(1);
        // owner_req low here, so a reasserting owner always clears instead.
        timeout_hit = in_xfer & ~owner_req & clk_en & (idle_cnt_d == TimeoutCnt);
    end

    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

    // Arbitration FSM with registered grant, pointer, idle counter and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            owner_q       <= '0;
            grant_q       <= '0;
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    grant_q <= '0;
                    if (|req) begin
                        state_q <= StArb;
                    end
                end
                StArb: begin
                    idle_cnt_q <= '0;
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        grant_q <= idx_to_onehot(pick_idx);
                        state_q <= StXfer;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StXfer: begin
                    if (xfer_fire && owner_last) begin
                        state_q    <= StIdle;
                        grant_q    <= '0;
                        ptr_q      <= owner_q + IDX_W'(1);
                        idle_cnt_q <= '0;
                    end else if (timeout_hit) begin
                        state_q       <= StIdle;
                        grant_q       <= '0;
                        ptr_q         <= owner_q + IDX_W'(1);
                        idle_cnt_q    <= '0;
                        timeout_err_q <= 1'b1;
                    end else if (xfer_fire || owner_req) begin
                        idle_cnt_q <= '0;
                    end else if (clk_en) begin
                        idle_cnt_q <= idle_cnt_d;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_tx_arbiter.sv
// Self-checking bench: requesters are byte queues, the expected byte stream is
// derived from round-robin message order, plus directed timing checks.
module tb_midi_tx_arbiter;

    localparam int unsigned TICKS = 3;

    logic        clk = 1'b0;
    logic        rst, clk_en, tx_valid, tx_ready, timeout_err;
    logic [3:0]  req, last, ack, grant;
    logic [31:0] data;
    logic [7:0]  tx_data;

    midi_tx_arbiter #(.TIMEOUT_TICKS(TICKS)) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .req         (req),
        .data        (data),
        .last        (last),
        .ack         (ack),
        .grant       (grant),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Each entry: {last, byte}.
    logic [8:0] msgq [4][$];
    // Each entry: {requester index, byte}.
    logic [9:0] got[$];
    logic [9:0] exp_q[$];

    logic [3:0] drop = 4'b0;
    logic rand_ready = 1'b0, ready_val = 1'b1, rand_en = 1'b0, rst_val = 1'b0;
    logic track_owner = 1'b1;
    int   cyc = 0, terr_seen = 0, idle_ticks = 0, msg_owner = -1, ptr_m = 0;

    logic [3:0] s_ack, s_grant;
    logic       s_valid, s_terr;
    logic [7:0] s_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < 4; i++) if (!drop[i]) p += msgq[i].size();
        return p;
    endfunction

    // One clock: drive requester state, sample mid-cycle, score, advance.
    task automatic run_cycle();
        logic [1:0] ii;
        rst      = rst_val;
        tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_val;
        clk_en   = rand_en ? ($urandom_range(0, 1) == 1) : (cyc % 4 == 0);
        for (int i = 0; i < 4; i++) begin
            if (!drop[i] && msgq[i].size() > 0) begin
                req[i]         = 1'b1;
                data[8*i +: 8] = msgq[i][0][7:0];
                last[i]        = msgq[i][0][8];
            end else begin
                req[i]         = 1'b0;
                data[8*i +: 8] = 8'h00;
                last[i]        = 1'b0;
            end
        end
        #1;
        s_ack = ack; s_grant = grant; s_valid = tx_valid; s_data = tx_data; s_terr = timeout_err;
        if (!rst_val) begin
            check("ack_in_grant", {28'd0, s_ack & ~s_grant}, 32'd0);
            if (track_owner && msg_owner >= 0)
                check("grant_hold", {28'd0, s_grant}, 32'd1 << msg_owner);
            if (clk_en && s_grant != 4'b0 && (s_grant & req) == 4'b0) idle_ticks++;
            if (s_terr) terr_seen++;
            for (int i = 0; i < 4; i++) begin
                if (s_ack[i] && msgq[i].size() > 0) begin
                    ii = 2'(i);
                    got.push_back({ii, s_data});
                    msg_owner = msgq[i][0][8] ? -1 : i;
                    void'(msgq[i].pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) msgq[i].delete();
        drop = 4'b0; ready_val = 1'b1; rst_val = 1'b1;
        run_cycle();
        rst_val = 1'b0; msg_owner = -1; terr_seen = 0; idle_ticks = 0; ptr_m = 0;
        got.delete(); exp_q.delete();
    endtask

    // Random message of 1..3 bytes for requester i.
    task automatic gen_msg(input int i);
        int len;
        logic lb;
        logic [7:0] b;
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) begin
            lb = (j == len - 1);
            b  = 8'($urandom);
            msgq[i].push_back({lb, b});
        end
    endtask

    // Everyone requesting at once: messages go out in rotation from the pointer.
    task automatic build_exp();
        int r, last_srv;
        logic [1:0] rr;
        last_srv = (ptr_m + 3) % 4;
        for (int k = 0; k < 4; k++) begin
            r  = (ptr_m + k) % 4;
            rr = 2'(r);
            for (int j = 0; j < msgq[r].size(); j++) exp_q.push_back({rr, msgq[r][j][7:0]});
            if (msgq[r].size() > 0) last_srv = r;
        end
        ptr_m = (last_srv + 1) % 4;
    endtask

    task automatic compare_sb(input string tag);
        check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            if (k < got.size()) check({tag, "_item"}, {22'd0, got[k]}, {22'd0, exp_q[k]});
        got.delete();
        exp_q.delete();
    endtask

    task automatic run_until_empty(input int budget, input string tag);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            run_cycle();
            n++;
        end
        check({tag, "_drain"}, 32'(pending()), 32'd0);
    endtask

    initial begin
        int dropped, rearmed, mask;

        // Reset state.
        do_reset();
        run_cycle();
        check("rst_grant", {28'd0, s_grant}, 32'd0);
        check("rst_valid", {31'd0, s_valid}, 32'd0);
        check("rst_ack", {28'd0, s_ack}, 32'd0);
        check("rst_terr", {31'd0, s_terr}, 32'd0);

        // Single three-byte message on requester 2.
        do_reset();
        msgq[2].push_back(9'h090); msgq[2].push_back(9'h03C); msgq[2].push_back(9'h17F);
        build_exp();
        run_cycle(); check("s1_idle_grant", {28'd0, s_grant}, 32'd0);
        run_cycle(); check("s1_arb_grant", {28'd0, s_grant}, 32'd0);
        check("s1_arb_valid", {31'd0, s_valid}, 32'd0);
        run_cycle(); check("s1_grant", {28'd0, s_grant}, 32'h4);
        check("s1_data0", {24'd0, s_data}, 32'h90);
        check("s1_ack0", {28'd0, s_ack}, 32'h4);
        run_cycle(); check("s1_data1", {24'd0, s_data}, 32'h3C);
        run_cycle(); check("s1_data2", {24'd0, s_data}, 32'h7F);
        check("s1_ack2", {28'd0, s_ack}, 32'h4);
        run_cycle(); check("s1_end_grant", {28'd0, s_grant}, 32'd0);
        check("s1_end_valid", {31'd0, s_valid}, 32'd0);
        compare_sb("s1");

        // Contention: all four request from pointer 0, random ready.
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 4; i++) gen_msg(i);
        build_exp();
        run_until_empty(300, "s2");
        run_cycle();
        compare_sb("s2");
        rand_ready = 1'b0;

        // Backpressure mid-message.
        do_reset();
        msgq[1].push_back(9'h0A1); msgq[1].push_back(9'h0B2); msgq[1].push_back(9'h1C3);
        build_exp();
        run_cycle(); run_cycle(); run_cycle();
        check("s3_ack0", {28'd0, s_ack}, 32'h2);
        ready_val = 1'b0;
        for (int n = 0; n < 5; n++) begin
            run_cycle();
            check("s3_bp_valid", {31'd0, s_valid}, 32'd1);
            check("s3_bp_data", {24'd0, s_data}, 32'hB2);
            check("s3_bp_ack", {28'd0, s_ack}, 32'd0);
        end
        ready_val = 1'b1;
        run_until_empty(20, "s3");
        run_cycle();
        compare_sb("s3");

        // Timeout: owner 0 stalls after its first byte, requester 3 waits.
        do_reset();
        track_owner = 1'b0;
        msgq[0].push_back(9'h090); msgq[0].push_back(9'h040); msgq[0].push_back(9'h160);
        msgq[3].push_back(9'h1F8);
        exp_q.push_back(10'h090); exp_q.push_back(10'h3F8);
        dropped = 0;
        for (int n = 0; n < 80 && terr_seen == 0; n++) begin
            run_cycle();
            if (dropped == 0 && got.size() >= 1) begin
                drop[0] = 1'b1; dropped = 1; idle_ticks = 0;
            end
        end
        check("s4_terr_seen", 32'(terr_seen), 32'd1);
        check("s4_ticks", 32'(idle_ticks), 32'd3);
        check("s4_grant_clr", {28'd0, s_grant}, 32'd0);
        msgq[0].delete(); drop[0] = 1'b0;
        run_until_empty(40, "s4");
        run_cycle();
        compare_sb("s4");
        check("s4_one_pulse", 32'(terr_seen), 32'd1);

        // Race: owner reasserts on the tick that would time it out.
        do_reset();
        msgq[0].push_back(9'h090); msgq[0].push_back(9'h140);
        exp_q.push_back(10'h090); exp_q.push_back(10'h040);
        dropped = 0; rearmed = 0;
        for (int n = 0; n < 80 && got.size() < 2; n++) begin
            if (dropped == 1 && rearmed == 0 && idle_ticks == 2 && cyc % 4 == 0) begin
                drop[0] = 1'b0; rearmed = 1;
            end
            run_cycle();
            if (dropped == 0 && got.size() == 1) begin
                drop[0] = 1'b1; dropped = 1; idle_ticks = 0;
            end
        end
        run_cycle();
        check("s5_rearmed", 32'(rearmed), 32'd1);
        check("s5_no_terr", 32'(terr_seen), 32'd0);
        compare_sb("s5");
        track_owner = 1'b1;

        // Reset after byte 1 of 3; pointer must be back at 0.
        do_reset();
        msgq[2].push_back(9'h091); msgq[2].push_back(9'h022); msgq[2].push_back(9'h133);
        for (int n = 0; n < 10 && got.size() < 1; n++) run_cycle();
        ready_val = 1'b0;
        msgq[2].delete();
        rst_val = 1'b1;
        run_cycle();
        rst_val = 1'b0; msg_owner = -1; ready_val = 1'b1;
        msgq[1].push_back(9'h1A5); msgq[3].push_back(9'h15A);
        run_cycle();
        check("s6_grant", {28'd0, s_grant}, 32'd0);
        check("s6_valid", {31'd0, s_valid}, 32'd0);
        check("s6_ack", {28'd0, s_ack}, 32'd0);
        check("s6_terr", {31'd0, s_terr}, 32'd0);
        exp_q.push_back(10'h291); exp_q.push_back(10'h1A5); exp_q.push_back(10'h35A);
        run_until_empty(40, "s6");
        run_cycle();
        compare_sb("s6");

        // Random rounds with a carried-over rotation pointer.
        do_reset();
        rand_ready = 1'b1; rand_en = 1'b1;
        for (int r = 0; r < 8; r++) begin
            mask = $urandom_range(1, 15);
            for (int i = 0; i < 4; i++) if (mask[i]) gen_msg(i);
            build_exp();
            run_until_empty(200, "rnd");
            run_cycle();
            run_cycle();
            compare_sb("rnd");
        end
        check("rnd_no_terr", 32'(terr_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
